madd_result_collector: RTL

// - Receive-side companion to the 8-lane int8 chain multiply-add (fixed latency, no stall, no valid).
// - Tracks which issued operand beats were real, aligns them with madd result, accumulates partial sums

---
 rtl/pe_collect_pkg.sv | 31 +++
 rtl/madd_result_collector_if.sv | 26 ++
 rtl/result_sync_fifo.sv | 52 +++++
 rtl/madd_result_collector.sv | 87 ++++++++
 4 files changed

// File: rtl/pe_collect_pkg.sv
// Shared widths, saturation bounds and the requantization helper
// used by the madd result collector.
package pe_collect_pkg;

    localparam int ACC_WIDTH  = 32;
    localparam int OUT_WIDTH  = 16;
    localparam int MADD_WIDTH = 32;

    localparam logic signed [ACC_WIDTH:0] SAT_HI =
        (ACC_WIDTH + 1)'(2 ** (OUT_WIDTH - 1) - 1);
    localparam logic signed [ACC_WIDTH:0] SAT_LO =
        (ACC_WIDTH + 1)'(-(2 ** (OUT_WIDTH - 1)));

    // One extra bit keeps the rounding add from wrapping.
    function automatic logic signed [OUT_WIDTH-1:0] shift_round_sat(
        input logic signed [ACC_WIDTH-1:0] acc,
        input logic [4:0]                  sh
    );
        logic signed [ACC_WIDTH:0] ext;
        logic signed [ACC_WIDTH:0] rnd;
        logic signed [ACC_WIDTH:0] r;
        ext = {acc[ACC_WIDTH-1], acc};
        rnd = '0;
        if (sh != 5'd0) rnd[sh - 5'd1] = 1'b1;
        r = (ext + rnd) >>> sh;
        if (r > SAT_HI) return SAT_HI[OUT_WIDTH-1:0];
        if (r < SAT_LO) return SAT_LO[OUT_WIDTH-1:0];
        return r[OUT_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/madd_result_collector_if.sv
// Issue-side and drain-side signals of the madd result collector;
// master is the PE side driving beats, slave is the collector.
interface madd_result_collector_if;
    import pe_collect_pkg::*;

    logic                         ivalid;
    logic                         ilast;
    logic                         iready;
    logic signed [MADD_WIDTH-1:0] madd_result;
    logic signed [ACC_WIDTH-1:0]  bias;
    logic [4:0]                   shift;
    logic                         ovalid;
    logic                         oready;
    logic signed [OUT_WIDTH-1:0]  odata;

    modport master (
        output ivalid, ilast, madd_result, bias, shift, oready,
        input  iready, ovalid, odata
    );

    modport slave (
        input  ivalid, ilast, madd_result, bias, shift, oready,
        output iready, ovalid, odata
    );

endinterface

// File: rtl/result_sync_fifo.sv
// Small synchronous FIFO for finished group results; the read port
// keeps showing the last popped word while empty.
module result_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] last_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW + 1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? last_q : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                last_q <= mem[rd_ptr];
            end
            count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end

endmodule

// File: rtl/madd_result_collector.sv
// Aligns issued beats with the fixed-latency madd output, accumulates each
// dot-product group, requantizes and queues results behind ready/valid.
module madd_result_collector
    import pe_collect_pkg::*;
#(
    parameter int MADD_LATENCY = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input logic                    clock,
    input logic                    reset,
    madd_result_collector_if.slave bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [MADD_LATENCY-1:0]     v_line;
    logic [MADD_LATENCY-1:0]     l_line;
    logic                        v_d;
    logic                        l_d;
    logic                        accept;
    logic                        first;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic                        push;
    logic signed [OUT_WIDTH-1:0] push_data;
    logic                        pop;
    logic                        full;
    logic                        empty;
    logic [CW-1:0]               count;
    logic [CW-1:0]               inflight;
    logic [CW:0]                 used;

    assign accept = bus.ivalid && bus.iready;
    assign v_d    = v_line[MADD_LATENCY-1];
    assign l_d    = l_line[MADD_LATENCY-1];

    // Credit covers both queued results and groups still in the pipe.
    assign used       = {1'b0, count} + {1'b0, inflight};
    assign bus.iready = !reset && (used < (CW + 1)'(FIFO_DEPTH));

    assign acc_next = (first ? bus.bias : acc)
                    + ACC_WIDTH'(bus.madd_result);

    always_ff @(posedge clock) begin
        if (reset) begin
            v_line    <= '0;
            l_line    <= '0;
            acc       <= '0;
            first     <= 1'b1;
            push      <= 1'b0;
            push_data <= '0;
            inflight  <= '0;
        end else begin
            v_line <= {v_line[MADD_LATENCY-2:0], accept};
            l_line <= {l_line[MADD_LATENCY-2:0], bus.ilast};
            if (v_d) begin
                acc   <= acc_next;
                first <= l_d;
            end
            push <= v_d && l_d;
            if (v_d && l_d) push_data <= shift_round_sat(acc_next, bus.shift);
            inflight <= inflight + CW'(accept && bus.ilast) - CW'(push);
        end
    end

    assign pop        = bus.ovalid && bus.oready;
    assign bus.ovalid = !empty;

    result_sync_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(OUT_WIDTH)
    ) u_fifo (
        .clock(clock),
        .reset(reset),
        .push(push),
        .pop(pop),
        .wdata(push_data),
        .rdata(bus.odata),
        .full(full),
        .empty(empty),
        .count(count)
    );

    a_no_overflow: assert property (
        @(posedge clock) disable iff (reset) !(push && full && !pop)
    );

endmodule
